// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-write scoreboard and one-register-per-cycle clear sweep
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NREAD   = 2,
  parameter logic [31:0] SP_INIT = 32'h7FF0,
  parameter logic [31:0] GP_INIT = 32'h4000,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         rd_i,
  input  logic [XLEN-1:0]       rd_data_i,
  input  logic                  rsv_i,
  input  logic [AW-1:0]         rsv_addr_i,
  input  logic [NREAD*AW-1:0]   rs_addr_i,
  output logic [NREAD*XLEN-1:0] rs_data_o,
  output logic [NREAD-1:0]      busy_o,
  input  logic                  clr_i,
  output logic                  ready_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            sweep_we;
  logic            wr_ok;
  logic            rsv_ok;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW-1:0]   port_addr [NREAD];

  function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx == AW'(2))
      v = XLEN'(SP_INIT);
    else if (idx == AW'(3))
      v = XLEN'(GP_INIT);
    return v;
  endfunction

  // Writebacks and reservations are only honoured while idle; index 0 is never stored or reserved.
  assign wr_ok  = we_i && ready_o && (rd_i != '0);
  assign rsv_ok = rsv_i && ready_o && (rsv_addr_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_o  = 1'b0;
    sweep_we = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (clr_i) begin
          state_d = SWEEP;
          cnt_d   = AW'(1);
        end
      end
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= init_val(AW'(i));
    end else if (sweep_we) begin
      regs_q[cnt_q] <= init_val(cnt_q);
    end else if (wr_ok) begin
      regs_q[rd_i] <= rd_data_i;
    end
  end

  // Reservation is applied after the writeback clear so the newer instruction keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)
      busy_d[rd_i] = 1'b0;
    if (rsv_ok)
      busy_d[rsv_addr_i] = 1'b1;
    if (sweep_we)
      busy_d[cnt_q] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_port_addr
    assign port_addr[g] = rs_addr_i[g*AW +: AW];
  end

  always_comb begin
    rs_data_o = '0;
    busy_o    = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (port_addr[k] != '0) begin
        rs_data_o[k*XLEN +: XLEN] = regs_q[port_addr[k]];
        busy_o[k]                 = busy_q[port_addr[k]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rd_i == port_addr[k])) begin
          rs_data_o[k*XLEN +: XLEN] = rd_data_i;
          busy_o[k]                 = rsv_ok && (rsv_addr_i == port_addr[k]);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (vector table plus scoreboard of read expectations)
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk_i  = 1'b0;
  logic                  clk_en = 1'b0;
  logic                  rst_i  = 1'b0;
  logic                  we_i   = 1'b0;
  logic [AW-1:0]         rd_i   = '0;
  logic [XLEN-1:0]       rd_data_i = '0;
  logic                  rsv_i  = 1'b0;
  logic [AW-1:0]         rsv_addr_i = '0;
  logic [NREAD*AW-1:0]   rs_addr_i = '0;
  logic [NREAD*XLEN-1:0] rs_data_o;
  logic [NREAD-1:0]      busy_o;
  logic                  clr_i  = 1'b0;
  logic                  ready_o;

  always #5 if (clk_en) clk_i = ~clk_i;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD),
    .SP_INIT(32'h7FF0), .GP_INIT(32'h4000)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .rd_i(rd_i), .rd_data_i(rd_data_i),
    .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i), .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
    .busy_o(busy_o), .clr_i(clr_i), .ready_o(ready_o)
  );

  typedef struct {
    int          tag;
    int          port;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic        b0;
    logic [31:0] e1;
    logic        b1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] fillv(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] initv(input int i);
    return (i == 2) ? 32'h7FF0 : (i == 3) ? 32'h4000 : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr_i = {a1, a0};
  endtask

  task automatic expect_rd(input int tag, input int port, input logic [4:0] addr,
                           input logic [31:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.port = port; e.addr = addr; e.data = d; e.busy = b;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("t%0d p%0d x%0d data", e.tag, e.port, e.addr),
          rs_data_o[e.port*XLEN +: XLEN], e.data);
      chk($sformatf("t%0d p%0d x%0d busy", e.tag, e.port, e.addr),
          {31'b0, busy_o[e.port]}, {31'b0, e.busy});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd7,  32'h0,        1'b1, 32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 5'd9,  32'hA5,       1'b1, 5'd9,  5'd9,  5'd9,  32'hA5,       1'b1, 32'hA5,       1'b1};
    vecs[4] = '{1'b1, 5'd9,  32'hA5,       1'b0, 5'd0,  5'd9,  5'd2,  32'hA5,       1'b0, 32'h7FF0,     1'b0};
    vecs[5] = '{1'b1, 5'd12, 32'h1111,     1'b1, 5'd13, 5'd12, 5'd13, 32'h1111,     1'b0, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd13, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 5'd13, 32'hBBBB,     1'b0, 5'd0,  5'd13, 5'd3,  32'hBBBB,     1'b0, 32'h4000,     1'b0};
    vecs[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    vecs[9] = '{1'b1, 5'd2,  32'h1234,     1'b0, 5'd0,  5'd2,  5'd0,  32'h1234,     1'b0, 32'h0,        1'b0};

    // Reset with the clock stopped: values must appear without any edge.
    set_rd(5'd2, 5'd3);
    #5 rst_i = 1'b1;
    expect_rd(0, 0, 5'd2, 32'h7FF0, 1'b0);
    expect_rd(0, 1, 5'd3, 32'h4000, 1'b0);
    drain();
    chk("reset ready", {31'b0, ready_o}, 32'd1);
    set_rd(5'd5, 5'd0);
    expect_rd(1, 0, 5'd5, 32'h0, 1'b0);
    expect_rd(1, 1, 5'd0, 32'h0, 1'b0);
    drain();
    clk_en = 1'b1;
    step();
    step();
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      we_i = vecs[i].we; rd_i = vecs[i].rd; rd_data_i = vecs[i].wdata;
      rsv_i = vecs[i].rsv; rsv_addr_i = vecs[i].rsv_addr;
      set_rd(5'd0, 5'd0);
      expect_rd(10 + i, 0, vecs[i].a0, vecs[i].e0, vecs[i].b0);
      expect_rd(10 + i, 1, vecs[i].a1, vecs[i].e1, vecs[i].b1);
      step();
      we_i = 1'b0; rsv_i = 1'b0;
      set_rd(vecs[i].a0, vecs[i].a1);
      drain();
    end

    // Same-cycle read of the register being written back.
    we_i = 1'b1; rd_i = 5'd4; rd_data_i = 32'hCAFE0001;
    set_rd(5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    expect_rd(100, 0, 5'd4, 32'hCAFE0001, 1'b0);
    expect_rd(100, 1, 5'd4, 32'hCAFE0001, 1'b0);
`else
    expect_rd(100, 0, 5'd4, 32'h0, 1'b0);
    expect_rd(100, 1, 5'd4, 32'h0, 1'b0);
`endif
    drain();
    step();
    we_i = 1'b0;
    expect_rd(101, 0, 5'd4, 32'hCAFE0001, 1'b0);
    drain();

    we_i = 1'b1; rd_data_i = 32'hCAFE0002; rsv_i = 1'b1; rsv_addr_i = 5'd4;
`ifdef REGFILE_BYPASS_EN
    expect_rd(102, 0, 5'd4, 32'hCAFE0002, 1'b1);
`else
    expect_rd(102, 0, 5'd4, 32'hCAFE0001, 1'b0);
`endif
    drain();
    step();
    we_i = 1'b0; rsv_i = 1'b0;
    expect_rd(103, 1, 5'd4, 32'hCAFE0002, 1'b1);
    drain();

    // Fill and reserve every register, then sweep.
    for (int i = 1; i < NREGS; i++) begin
      we_i = 1'b1; rd_i = 5'(i); rd_data_i = fillv(i);
      rsv_i = 1'b1; rsv_addr_i = 5'(i);
      step();
    end
    we_i = 1'b0; rsv_i = 1'b0;
    set_rd(5'd2, 5'd31);
    expect_rd(110, 0, 5'd2, fillv(2), 1'b1);
    expect_rd(110, 1, 5'd31, fillv(31), 1'b1);
    drain();

    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    low = 0;
    for (int c = 1; c <= 40; c++) begin
      if (ready_o) break;
      low++;
      we_i       = (c == 5) || (c == 20);
      rd_i       = (c == 5) ? 5'd10 : 5'd5;
      rd_data_i  = (c == 5) ? 32'h999 : 32'h555;
      rsv_i      = (c == 20);
      rsv_addr_i = 5'd5;
      clr_i      = (c == 15);
      if (c == 6) begin
        set_rd(5'd10, 5'd0);
        expect_rd(111, 0, 5'd10, fillv(10), 1'b1);
        expect_rd(111, 1, 5'd0, 32'h0, 1'b0);
        drain();
      end
      if (c == 10) begin
        set_rd(5'd5, 5'd20);
        expect_rd(112, 0, 5'd5, 32'h0, 1'b0);
        expect_rd(112, 1, 5'd20, fillv(20), 1'b1);
        drain();
      end
      step();
    end
    we_i = 1'b0; rsv_i = 1'b0; clr_i = 1'b0;
    chk("sweep ready-low cycles", 32'(low), 32'd31);
    for (int i = 0; i < NREGS; i += 2) begin
      set_rd(5'(i), 5'(i + 1));
      expect_rd(120, 0, 5'(i), initv(i), 1'b0);
      expect_rd(120, 1, 5'(i + 1), initv(i + 1), 1'b0);
      drain();
    end

    // Reset in the middle of a sweep.
    we_i = 1'b1; rd_i = 5'd25; rd_data_i = 32'h5; rsv_i = 1'b1; rsv_addr_i = 5'd26;
    step();
    we_i = 1'b0; rsv_i = 1'b0;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    for (int c = 1; c < 12; c++) step();
    chk("mid-sweep ready before reset", {31'b0, ready_o}, 32'd0);
    #2 rst_i = 1'b1;
    set_rd(5'd2, 5'd3);
    expect_rd(130, 0, 5'd2, 32'h7FF0, 1'b0);
    expect_rd(130, 1, 5'd3, 32'h4000, 1'b0);
    drain();
    chk("mid-sweep reset ready", {31'b0, ready_o}, 32'd1);
    set_rd(5'd25, 5'd26);
    expect_rd(131, 0, 5'd25, 32'h0, 1'b0);
    expect_rd(131, 1, 5'd26, 32'h0, 1'b0);
    drain();
    step();
    rst_i = 1'b0;
    step();
    chk("post-reset ready", {31'b0, ready_o}, 32'd1);
    we_i = 1'b1; rd_i = 5'd20; rd_data_i = 32'h77;
    step();
    we_i = 1'b0;
    set_rd(5'd20, 5'd0);
    expect_rd(132, 0, 5'd20, 32'h77, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
